dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 148 ++++++++++++++
 tb/tb_dmem_responder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-lane data memory responder with fixed response latency
module dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 8,
    parameter int LATENCY     = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [XLEN-1:0] req_addr,
    input  logic [2:0]      req_width,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int NB = XLEN / 8;
    localparam logic [XLEN-1:0] LIMIT = XLEN'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_next;
    logic [3:0]      cnt, cnt_next;
    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic            accept;
    logic            err;
    logic [AW-1:0]   widx;
    logic [4:0]      shamt;
    logic [XLEN-1:0] word, shifted, store_data, load_data;
    logic [NB-1:0]   be;

    assign req_ready = reset && (state == IDLE);
    assign rsp_valid = reset && (state == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid ? err_q : 1'b0;
    assign accept    = req_valid && req_ready;

    assign widx       = req_addr[AW+1:2];
    assign shamt      = {req_addr[1:0], 3'b000};
    assign word       = mem[widx];
    assign shifted    = word >> shamt;
    assign store_data = req_wdata << shamt;

    always_comb begin
        err = 1'b0;
        if (req_addr >= LIMIT)
            err = 1'b1;
        case (req_width)
            3'b000, 3'b100: ;
            3'b001, 3'b101: if (req_addr[0]) err = 1'b1;
            3'b010:         if (req_addr[1:0] != 2'b00) err = 1'b1;
            default:        err = 1'b1;
        endcase
        if (req_wen && (req_width == 3'b100 || req_width == 3'b101))
            err = 1'b1;
    end

    always_comb begin
        be = '0;
        case (req_width)
            3'b000:  be = {{(NB-1){1'b0}}, 1'b1} << req_addr[1:0];
            3'b001:  be = {{(NB-2){1'b0}}, 2'b11} << {req_addr[1], 1'b0};
            3'b010:  be = '1;
            default: be = '0;
        endcase
    end

    always_comb begin
        load_data = '0;
        case (req_width)
            3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            3'b010:  load_data = shifted;
            default: load_data = '0;
        endcase
    end

    // Stores commit at the acceptance edge so any later load sees them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= '0;
        end else if (accept && req_wen && !err) begin
            for (int b = 0; b < NB; b++)
                if (be[b])
                    mem[widx][b*8 +: 8] <= store_data[b*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            rdata_q <= (err || req_wen) ? '0 : load_data;
            err_q   <= err;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY > 1) begin
                        state_next = WAIT;
                        cnt_next   = 4'(LATENCY - 1);
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at latency 1 and 3
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_width = 3'b010;
    logic [31:0] req_wdata = '0;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    logic        rq, rv, re;
    logic [31:0] rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_responder dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && !sel), .req_ready(a_req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_width(req_width), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready && !sel),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_responder #(.LATENCY(3)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && sel), .req_ready(b_req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_width(req_width), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready && sel),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    assign rq = sel ? b_req_ready : a_req_ready;
    assign rv = sel ? b_rsp_valid : a_rsp_valid;
    assign re = sel ? b_rsp_err   : a_rsp_err;
    assign rd = sel ? b_rsp_rdata : a_rsp_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic s, input logic wen, input logic [31:0] addr,
                        input logic [2:0] w, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input string tag);
        int n;
        @(negedge clk);
        sel = s; req_wen = wen; req_addr = addr; req_width = w; req_wdata = wd;
        req_valid = 1'b1; rsp_ready = 1'b1;
        check({tag, "_req_ready"}, {31'b0, rq}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0; req_wen = ~wen; req_addr = 32'hFFFF_FFFC;
        req_width = 3'b010; req_wdata = 32'hFFFF_FFFF;
        n = 1;
        while (!rv && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, lat);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, {31'b0, re}, {31'b0, exp_err});
        @(negedge clk);
        check({tag, "_idle"}, {30'b0, rq, rv}, 32'd2);
        check({tag, "_rdata_idle"}, rd, 32'd0);
    endtask

    initial begin
        #1;
        check("rst_a", {30'b0, a_req_ready, a_rsp_valid}, 32'd0);
        check("rst_b", {30'b0, b_req_ready, b_rsp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_ready", {30'b0, a_req_ready, b_req_ready}, 32'd3);

        xact(0, 1, 32'h4, 3'b010, 32'hDEADBEEF, 32'h0, 0, 1, "sw4");
        xact(0, 0, 32'h4, 3'b010, 32'h0, 32'hDEADBEEF, 0, 1, "lw4");
        xact(0, 1, 32'h5, 3'b000, 32'h0000_0080, 32'h0, 0, 1, "sb5");
        xact(0, 0, 32'h5, 3'b000, 32'h0, 32'hFFFF_FF80, 0, 1, "lb5");
        xact(0, 0, 32'h5, 3'b100, 32'h0, 32'h0000_0080, 0, 1, "lbu5");
        xact(0, 0, 32'h4, 3'b010, 32'h0, 32'hDEAD80EF, 0, 1, "lw4b");
        xact(0, 0, 32'h6, 3'b001, 32'h0, 32'hFFFF_DEAD, 0, 1, "lh6");
        xact(0, 0, 32'h6, 3'b101, 32'h0, 32'h0000_DEAD, 0, 1, "lhu6");
        xact(0, 1, 32'h0, 3'b001, 32'hAAAA_7FFF, 32'h0, 0, 1, "sh0");
        xact(0, 0, 32'h0, 3'b001, 32'h0, 32'h0000_7FFF, 0, 1, "lh0");
        xact(0, 0, 32'h0, 3'b010, 32'h0, 32'h0000_7FFF, 0, 1, "lw0");

        xact(0, 0, 32'h2, 3'b010, 32'h0, 32'h0, 1, 1, "err_lw2");
        xact(0, 1, 32'h3, 3'b001, 32'h1234_5678, 32'h0, 1, 1, "err_sh3");
        xact(0, 0, 32'h20, 3'b010, 32'h0, 32'h0, 1, 1, "err_lw20");
        xact(0, 0, 32'h0, 3'b011, 32'h0, 32'h0, 1, 1, "err_w011");
        xact(0, 1, 32'h4, 3'b100, 32'h0000_0011, 32'h0, 1, 1, "err_sbu");
        xact(0, 1, 32'h1C, 3'b010, 32'h0, 32'h0, 0, 1, "sw1c");
        xact(0, 1, 32'h20, 3'b010, 32'h5555_5555, 32'h0, 1, 1, "err_sw20");
        xact(0, 0, 32'h4, 3'b010, 32'h0, 32'hDEAD80EF, 0, 1, "lw4_kept");
        xact(0, 0, 32'h0, 3'b010, 32'h0, 32'h0000_7FFF, 0, 1, "lw0_kept");

        xact(1, 1, 32'h0, 3'b010, 32'h1122_3344, 32'h0, 0, 3, "b_sw0");
        @(negedge clk);
        sel = 1'b1; req_wen = 1'b0; req_addr = 32'h0; req_width = 3'b010;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 32'h4;
        check("hold_c1", {30'b0, rq, rv}, 32'd0);
        @(negedge clk);
        check("hold_c2", {30'b0, rq, rv}, 32'd0);
        @(negedge clk);
        check("hold_c3", {30'b0, rq, rv}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("hold_rdata", rd, 32'h1122_3344);
            check("hold_flags", {30'b0, rq, rv}, 32'd1);
            if (i < 4) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hold_release", {30'b0, rq, rv}, 32'd2);

        xact(1, 1, 32'h4, 3'b010, 32'hCAFE_F00D, 32'h0, 0, 3, "b_sw4");
        @(negedge clk);
        sel = 1'b1; req_wen = 1'b0; req_addr = 32'h4; req_width = 3'b010;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_rst", {30'b0, rq, rv}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_rsp_after_rst", {31'b0, rv}, 32'd0);
        end
        xact(1, 0, 32'h4, 3'b010, 32'h0, 32'h0, 0, 3, "b_lw4_cleared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
